// File: rtl/ce_pkg.sv
// Shared types and constants for the clock-enable generator and its reset sequencer.
package ce_pkg;

   localparam int unsigned RCNT_W = 16;
   localparam int unsigned DIV_W  = 3;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } seq_state_t;

   // Next sequencer state; loss of lock wins over every other transition.
   function automatic seq_state_t seq_next(input seq_state_t        st,
                                           input logic [RCNT_W-1:0] rcnt,
                                           input logic              locked_s,
                                           input logic [RCNT_W-1:0] last);
      seq_state_t nxt;
      nxt = HOLD;
      if (locked_s) begin
         case (st)
            HOLD:    nxt = COUNT;
            COUNT:   nxt = (rcnt == last) ? RUN : COUNT;
            RUN:     nxt = RUN;
            default: nxt = HOLD;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ce_gen_sync2.sv
// Two-flop synchroniser with synchronous reset, for bringing PLL lock into the clock70 domain.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ce_gen.sv
// Clock-enable generator (3.5 MHz / 1.75 MHz / contended CPU enables) plus CPU reset sequencer.
// Optional build macro CE_TURBO_EN adds the turbo port and its div=7 sampled register.
module ce_gen
   import ce_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 1024
) (
   input  logic clock70,
   input  logic reset,
   input  logic locked,
   input  logic contend,
`ifdef CE_TURBO_EN
   input  logic turbo,
`endif
   output logic ce35p,
   output logic ce35n,
   output logic ce175,
   output logic cecpu_p,
   output logic cecpu_n,
   output logic cpu_reset,
   output logic ready
);

   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

   logic              locked_s;
   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [RCNT_W-1:0] rcnt;
   logic [DIV_W-1:0]  div;
   logic [DIV_W-1:0]  div_nxt;
   logic              stall;
   logic              stall_nxt;
   logic              turbo_nxt;

   sync2 u_sync (
      .clk   (clock70),
      .reset (reset),
      .d     (locked),
      .q     (locked_s)
   );

   assign state_nxt = seq_next(state, rcnt, locked_s, RCNT_LAST);

   // Reset sequencer: HOLD until lock, COUNT RESET_CYCLES cycles, then RUN.
   always_ff @(posedge clock70) begin
      if (reset) begin
         state     <= HOLD;
         rcnt      <= '0;
         cpu_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cpu_reset <= (state_nxt != RUN);
         ready     <= (state_nxt == RUN);
         if (state_nxt == HOLD) begin
            rcnt <= '0;
         end else if (state == COUNT) begin
            rcnt <= rcnt + RCNT_W'(1);
         end
      end
   end

`ifdef CE_TURBO_EN
   logic turbo_q;

   assign turbo_nxt = (&div) ? turbo : turbo_q;

   always_ff @(posedge clock70) begin
      if (reset) begin
         turbo_q <= 1'b0;
      end else begin
         turbo_q <= turbo_nxt;
      end
   end
`else
   assign turbo_nxt = 1'b0;
`endif

   // Stall samples contention on ce35n cycles and is held clear while the CPU is in reset.
   always_comb begin
      div_nxt   = div + DIV_W'(1);
      stall_nxt = ce35n ? contend : stall;
      if (state_nxt != RUN) begin
         stall_nxt = 1'b0;
      end
   end

   // Enables are registered from the next divider/stall values so they line up with div and stall.
   always_ff @(posedge clock70) begin
      if (reset) begin
         div     <= '0;
         stall   <= 1'b0;
         ce35p   <= 1'b0;
         ce35n   <= 1'b0;
         ce175   <= 1'b0;
         cecpu_p <= 1'b0;
         cecpu_n <= 1'b0;
      end else begin
         div     <= div_nxt;
         stall   <= stall_nxt;
         ce35p   <= div_nxt[0];
         ce35n   <= ~div_nxt[0];
         ce175   <= &div_nxt[1:0];
         cecpu_p <= turbo_nxt | (div_nxt[0] & ~stall_nxt);
         cecpu_n <= turbo_nxt | (~div_nxt[0] & ~stall_nxt);
      end
   end

endmodule

// File: doc/ce_gen.md
CE_GEN -- requirements
Module: ce_gen

Interface
REQ-001 Parameter: RESET_CYCLES, 1024, number of clock70 cycles cpu_reset is held after PLL lock is seen; legal range 1..65535.
REQ-002 Port: clock70  in  1  7.00 MHz system clock from the PLL output buffer; the only clock in the block.
REQ-003 Port: reset  in  1  synchronous, active-high reset, sampled on the clock70 rising edge.
REQ-004 Port: locked  in  1  PLL lock indication, asynchronous to clock70.
REQ-005 Port: contend  in  1  ULA memory-contention request; stalls CPU enables.
REQ-006 Port: turbo  in  1  CPU turbo request; present only when CE_TURBO_EN is defined.
REQ-007 Port: ce35p  out  1  3.5 MHz positive-phase enable.
REQ-008 Port: ce35n  out  1  3.5 MHz negative-phase enable.
REQ-009 Port: ce175  out  1  1.75 MHz enable for the sound chip.
REQ-010 Port: cecpu_p  out  1  CPU positive-phase enable, after contention gating.
REQ-011 Port: cecpu_n  out  1  CPU negative-phase enable, after contention gating.
REQ-012 Port: cpu_reset  out  1  active-high reset to the CPU and peripherals.
REQ-013 Port: ready  out  1  high while the reset sequencer is in RUN.

Function
REQ-014 3-bit divider counter div SHALL increment by 1 every clock70 cycle and wrap from 7 to 0.
REQ-015 ce35n SHALL be 1 exactly when div[0]=0; ce35p exactly when div[0]=1; ce175 exactly when div[1:0]=3.
REQ-016 Enables SHALL be single-cycle pulses decoded from registered state only; no combinational path from any input to ce35p, ce35n or ce175.
REQ-017 Stall register SHALL load contend only in cycles where ce35n=1, and hold its value otherwise.
REQ-018 cecpu_p SHALL equal ce35p AND NOT stall; cecpu_n SHALL equal ce35n AND NOT stall.
REQ-019 Stall SHALL be forced to 0 while cpu_reset=1; CPU enables keep running during cpu_reset.
REQ-020 locked SHALL pass through a 2-flop synchroniser (locked_s) before any use.
REQ-021 Sequencer states: HOLD, COUNT, RUN, plus a 16-bit cycle counter rcnt.
REQ-022 HOLD: rcnt=0; go to COUNT when locked_s=1.
REQ-023 COUNT: rcnt increments each cycle; go to RUN in the cycle rcnt=RESET_CYCLES-1.
REQ-024 RUN: stay until locked_s=0.
REQ-025 In any state, locked_s=0 SHALL force HOLD on the next edge, with rcnt=0.
REQ-026 cpu_reset = (state != RUN); ready = (state == RUN).
REQ-027 Timing: with locked steady at 1 and reset first sampled low at edge 0, cpu_reset SHALL fall immediately after edge RESET_CYCLES+2.

Reset
REQ-028 While reset=1, on each edge: div=0, stall=0, synchroniser flops=0, state=HOLD, rcnt=0.
REQ-029 While reset=1, ce35p, ce35n, ce175, cecpu_p and cecpu_n SHALL all be 0, cpu_reset=1 and ready=0.
REQ-030 Asserting reset mid-sequence or in RUN SHALL restart the full sequence, identical to power-up.

Configuration
REQ-031 Macro CE_TURBO_EN: when defined, the turbo port exists and a register turbo_q loads turbo only in cycles where div=7.
REQ-032 With turbo_q=1, cecpu_p and cecpu_n SHALL both be 1 every cycle (outside reset) and contention SHALL be ignored.
REQ-033 When CE_TURBO_EN is undefined, the turbo port and turbo_q SHALL be absent and the behaviour SHALL equal turbo_q=0.

Structure
REQ-034 Shared package ce_pkg SHALL hold the sequencer state enum (HOLD, COUNT, RUN) and the constant RCNT_W=16.
REQ-035 The 2-flop synchroniser SHALL be a separate sub-module, sync2, with a reset input.

Verification
REQ-036 Reset low, locked=1, RESET_CYCLES=4: cpu_reset falls after edge 6 and ready rises at the same time.
REQ-037 Free run, contend=0 for 16 cycles: ce35p and ce35n alternate every cycle, and ce175 pulses on cycles 3, 7, 11, 15 after reset release.
REQ-038 contend=1 held across two ce35n cycles: cecpu_p and cecpu_n are 0 from the first ce35n until the first ce35n with contend=0 plus one cycle, while ce35p and ce35n stay unaffected.
REQ-039 locked drops for 1 cycle in RUN: 2 cycles later state is HOLD and cpu_reset=1; after lock returns, cpu_reset stays high a further RESET_CYCLES+2 cycles.
REQ-040 reset asserted during COUNT with rcnt=2: all enables are 0 and cpu_reset=1 on the next edge, and the sequence restarts from edge 0.
REQ-041 CE_TURBO_EN build, turbo raised at div=3: there is no change until div=7 is sampled, after which cecpu_p=cecpu_n=1 every cycle even with contend=1.
